// File: rtl/comp_pkg.sv
// Shared types for the dictionary compressor: command/response codes,
// engine FSM states and a saturating counter helper.
package comp_pkg;

  typedef enum logic [1:0] {
    CMD_NOP    = 2'b00,
    CMD_COMP   = 2'b01,
    CMD_DECOMP = 2'b10,
    CMD_ILL    = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    RSP_NONE   = 2'b00,
    RSP_COMP   = 2'b01,
    RSP_DECOMP = 2'b10,
    RSP_ERR    = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SEARCH = 2'b01,
    ST_LOOKUP = 2'b10,
    ST_RESP   = 2'b11
  } state_e;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/comp_dict.sv
// Dictionary storage: append-only entry array with fill count.
// Ports: clk, reset (sync, high), we_i/wdata_i append port,
// ridx_i/rdata_o combinational read, count_o fill level, full_o.
module comp_dict #(
  parameter int DATA_WIDTH = 8,
  parameter int DICT_DEPTH = 4,
  parameter int IDX_W      = $clog2(DICT_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [IDX_W-1:0]      ridx_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [IDX_W:0]        count_o,
  output logic                  full_o
);
  import comp_pkg::*;

  // Sized to the full index space so any ridx_i is in range;
  // slots at or above count_q are never treated as valid.
  logic [DATA_WIDTH-1:0] mem_q [2**IDX_W];
  logic [IDX_W:0]        cnt_q;

  assign full_o  = (cnt_q == (IDX_W+1)'(DICT_DEPTH));
  assign count_o = cnt_q;
  assign rdata_o = mem_q[ridx_i];

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (we_i && !full_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we_i && !full_o) begin
      mem_q[cnt_q[IDX_W-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/comp_decomp_engine.sv
// Dictionary compress/decompress responder: FSM plus output registers.
// Ports: clk, reset (sync, high), command, data_in, compressed_in,
// compressed_out, decompressed_out, response (1-cycle pulse), busy.
// `define COMP_STATS_EN adds hit_cnt/miss_cnt/err_cnt (saturating).
module comp_decomp_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int DICT_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            command,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0] compressed_in,
  output logic [DATA_WIDTH-1:0] compressed_out,
  output logic [DATA_WIDTH-1:0] decompressed_out,
  output logic [1:0]            response,
`ifdef COMP_STATS_EN
  output logic [15:0]           hit_cnt,
  output logic [15:0]           miss_cnt,
  output logic [15:0]           err_cnt,
`endif
  output logic                  busy
);
  import comp_pkg::*;

  localparam int IDX_W = $clog2(DICT_DEPTH);
  localparam int CW    = IDX_W + 1;

  state_e                state_q, state_d;
  resp_e                 code_q, code_d;
  resp_e                 resp_q;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]         ptr_q, ptr_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] cout_q, dout_q;

  logic [IDX_W-1:0]      ridx;
  logic [DATA_WIDTH-1:0] rdata;
  logic [CW-1:0]         cnt;
  logic                  full, we, at_end, hit;
  logic                  unused_cin;

  // Only the low IDX_W bits of compressed_in carry an index.
  assign unused_cin = ^(compressed_in >> IDX_W);

  comp_dict #(
    .DATA_WIDTH(DATA_WIDTH),
    .DICT_DEPTH(DICT_DEPTH),
    .IDX_W     (IDX_W)
  ) u_dict (
    .clk    (clk),
    .reset  (reset),
    .we_i   (we),
    .wdata_i(data_q),
    .ridx_i (ridx),
    .rdata_o(rdata),
    .count_o(cnt),
    .full_o (full)
  );

  assign ridx   = (state_q == ST_LOOKUP) ? idx_q
                                         : ptr_q[IDX_W-1:0];
  assign at_end = (ptr_q == cnt);
  assign hit    = !at_end && (rdata == data_q);

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    data_d  = data_q;
    res_d   = res_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    we      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        unique case (cmd_e'(command))
          CMD_COMP: begin
            data_d  = data_in;
            ptr_d   = '0;
            state_d = ST_SEARCH;
          end
          CMD_DECOMP: begin
            idx_d   = compressed_in[IDX_W-1:0];
            state_d = ST_LOOKUP;
          end
          CMD_ILL: begin
            code_d  = RSP_ERR;
            state_d = ST_RESP;
          end
          CMD_NOP: ;
        endcase
      end
      ST_SEARCH: begin
        unique case (1'b1)
          hit: begin
            res_d   = DATA_WIDTH'(ptr_q[IDX_W-1:0]);
            code_d  = RSP_COMP;
            state_d = ST_RESP;
          end
          at_end && !full: begin
            we      = 1'b1;
            res_d   = DATA_WIDTH'(cnt[IDX_W-1:0]);
            code_d  = RSP_COMP;
            state_d = ST_RESP;
          end
          at_end && full: begin
            code_d  = RSP_ERR;
            state_d = ST_RESP;
          end
          default: ptr_d = ptr_q + 1'b1;
        endcase
      end
      ST_LOOKUP: begin
        state_d = ST_RESP;
        if ({1'b0, idx_q} < cnt) begin
          res_d  = rdata;
          code_d = RSP_DECOMP;
        end else begin
          code_d = RSP_ERR;
        end
      end
      ST_RESP: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      code_q  <= RSP_NONE;
      resp_q  <= RSP_NONE;
      data_q  <= '0;
      res_q   <= '0;
      ptr_q   <= '0;
      idx_q   <= '0;
      cout_q  <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      data_q  <= data_d;
      res_q   <= res_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      resp_q  <= RSP_NONE;
      if (state_q == ST_RESP) begin
        resp_q <= code_q;
        if (code_q == RSP_COMP)   cout_q <= res_q;
        if (code_q == RSP_DECOMP) dout_q <= res_q;
      end
    end
  end

  assign compressed_out   = cout_q;
  assign decompressed_out = dout_q;
  assign response         = resp_q;
  assign busy             = (state_q != ST_IDLE);

`ifdef COMP_STATS_EN
  logic [15:0] hit_q, miss_q, err_q;
  logic        err_ev;

  // Counted as the outcome is decided, i.e. on entry to RESP.
  assign err_ev = (state_q != ST_RESP) && (state_d == ST_RESP)
                  && (code_d == RSP_ERR);

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_q  <= '0;
      miss_q <= '0;
      err_q  <= '0;
    end else begin
      if (state_q == ST_SEARCH && hit) hit_q <= sat_inc(hit_q);
      if (we && !full) miss_q <= sat_inc(miss_q);
      if (err_ev) err_q <= sat_inc(err_q);
    end
  end

  assign hit_cnt  = hit_q;
  assign miss_cnt = miss_q;
  assign err_cnt  = err_q;
`endif

endmodule
